// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, an optional skid entry and flush.
// Control is zeroed on every bubble, so a dead slot never shows RegWrite or MemWrite.
module pipe_stage_reg #(
    parameter int unsigned CTRL_W = 8,
    parameter int unsigned DATA_W = 64,
    parameter int unsigned PC_W   = 32,
    parameter int unsigned SKID   = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    input  logic [PC_W-1:0]   in_pc,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [PC_W-1:0]   out_pc,
    output logic [1:0]        occupancy
);

    localparam bit HasSkid = (SKID != 0);

    logic              main_valid_q, main_valid_d;
    logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
    logic [DATA_W-1:0] main_data_q, main_data_d;
    logic [PC_W-1:0]   main_pc_q, main_pc_d;

    logic              skid_valid_q, skid_valid_d;
    logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic [PC_W-1:0]   skid_pc_q, skid_pc_d;

    logic [1:0]        occ_q, occ_d;
    logic              accept, drain;

    // With a skid entry in_ready depends only on state, breaking the out_ready path.
    assign in_ready = HasSkid ? !skid_valid_q : (!main_valid_q || out_ready);
    assign accept   = in_valid && in_ready;
    assign drain    = main_valid_q && out_ready;

    always_comb begin
        main_valid_d = main_valid_q;
        main_ctrl_d  = main_ctrl_q;
        main_data_d  = main_data_q;
        main_pc_d    = main_pc_q;
        skid_valid_d = skid_valid_q;
        skid_ctrl_d  = skid_ctrl_q;
        skid_data_d  = skid_data_q;
        skid_pc_d    = skid_pc_q;

        if (flush) begin
            // Data and pc are left in place; only valid and control matter for a bubble.
            main_valid_d = 1'b0;
            main_ctrl_d  = '0;
            skid_valid_d = 1'b0;
            skid_ctrl_d  = '0;
        end else if (HasSkid && drain && skid_valid_q) begin
            main_valid_d = 1'b1;
            main_ctrl_d  = skid_ctrl_q;
            main_data_d  = skid_data_q;
            main_pc_d    = skid_pc_q;
            skid_valid_d = 1'b0;
            skid_ctrl_d  = '0;
        end else if (accept && (!main_valid_q || drain)) begin
            main_valid_d = 1'b1;
            main_ctrl_d  = in_ctrl;
            main_data_d  = in_data;
            main_pc_d    = in_pc;
        end else if (HasSkid && accept) begin
            skid_valid_d = 1'b1;
            skid_ctrl_d  = in_ctrl;
            skid_data_d  = in_data;
            skid_pc_d    = in_pc;
        end else if (drain) begin
            main_valid_d = 1'b0;
            main_ctrl_d  = '0;
        end

        occ_d = {main_valid_d & skid_valid_d, main_valid_d ^ skid_valid_d};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            main_valid_q <= 1'b0;
            main_ctrl_q  <= '0;
            main_data_q  <= '0;
            main_pc_q    <= '0;
            skid_valid_q <= 1'b0;
            skid_ctrl_q  <= '0;
            skid_data_q  <= '0;
            skid_pc_q    <= '0;
            occ_q        <= 2'd0;
        end else begin
            main_valid_q <= main_valid_d;
            main_ctrl_q  <= main_ctrl_d;
            main_data_q  <= main_data_d;
            main_pc_q    <= main_pc_d;
            skid_valid_q <= skid_valid_d;
            skid_ctrl_q  <= skid_ctrl_d;
            skid_data_q  <= skid_data_d;
            skid_pc_q    <= skid_pc_d;
            occ_q        <= occ_d;
        end
    end

    assign out_valid = main_valid_q;
    assign out_ctrl  = main_ctrl_q;
    assign out_data  = main_data_q;
    assign out_pc    = main_pc_q;
    assign occupancy = occ_q;

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
Parametrised pipeline stage register for the five-stage CPU, covering D/E, E/M and M/W. It adds a valid/ready handshake, an optional skid entry, a synchronous flush that inserts a bubble, and a control field that is cleared on every bubble. Payload fields (ALU result, store data, write register, pc, jal flag, Rt, …) are packed by the instantiating stage into ctrl/data buses.

Parameters:
CTRL_W, 8, width of the control bundle (RegWrite, MemtoReg, MemWrite, jal, …); forced to 0 on any bubble.
DATA_W, 64, width of the data bundle (ALUOut, WriteData, WriteReg, Rt, …); not cleared on flush.
PC_W, 32, width of the pc field, carried for exception and debug reporting.
SKID, 1, 1 adds a second (skid) entry so in_ready is registered; 0 gives a single entry with a combinational in_ready.

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous, active-high
in_valid  input  1  upstream stage holds a valid instruction
in_ready  output  1  this register accepts in_* this cycle
in_ctrl  input  CTRL_W  control bundle from upstream
in_data  input  DATA_W  data bundle from upstream
in_pc  input  PC_W  instruction pc
flush  input  1  kill all held contents and the incoming beat (branch or exception)
out_valid  output  1  output entry holds a valid instruction
out_ready  input  1  downstream accepts (not stalled)
out_ctrl  output  CTRL_W  registered control; 0 whenever out_valid=0
out_data  output  DATA_W  registered data
out_pc  output  PC_W  registered pc
occupancy  output  2  number of held entries, 0..2 (0..1 when SKID=0)

Behaviour:
- Handshakes: accept when in_valid && in_ready; drain when out_valid && out_ready.
- Entries: main (drives out_*) and skid (present only when SKID=1). All outputs are registered.
- Latency: 1 cycle from accept to out_valid. Throughput is 1 beat/cycle while out_ready=1.
- Reset: out_valid=0, skid_valid=0, and out_ctrl/out_data/out_pc=0, skid contents=0, occupancy=0. After reset, in_ready=1.
- SKID=1:
  - in_ready = !skid_valid (registered, no combinational path from out_ready).
  - Per-cycle moves:
    - main empty, or main draining with skid empty: accepted beat loads main.
    - main held (out_valid && !out_ready) and beat accepted: beat loads skid.
    - main draining and skid full: skid moves to main and skid_valid clears. in_ready was 0, so no accept happens that cycle.
  - FIFO order is preserved; no beat is lost or duplicated.
- SKID=0:
  - in_ready = !out_valid || out_ready.
  - Accepted beat loads main; a drain with no accept clears out_valid.
- Flush (highest priority after reset):
  - Next edge: out_valid=0, skid_valid=0, out_ctrl=0, skid ctrl=0, occupancy=0.
  - The beat offered that cycle is dropped, even if in_valid && in_ready.
  - out_data and out_pc hold their previous values.
- Bubble rule: any cycle main is not loaded and main drains (or is empty) → out_valid=0 and out_ctrl=0. No spurious RegWrite/MemWrite can ever be visible.
- Hold: out_valid && !out_ready → all out_* stable until drained.
- occupancy = out_valid + skid_valid, registered.
- Reset mid-operation overrides flush and the handshakes; held beats are discarded.

Test Plan:
- Streaming, SKID=1: beats pc=0x3000,0x3004,0x3008 with ctrl=0x05 back-to-back, out_ready=1 → out_pc follows 1 cycle later, out_ctrl=0x05, occupancy=1 steady.
- Stall fill: out_ready=0 from cycle 2 while beats A,B,C are offered → A held in main, B in skid, in_ready=0, C waits. Raise out_ready → A, B, C emerge in order, one per cycle.
- Flush mid-stall: main=A, skid=B, flush=1 with C offered → next cycle out_valid=0, out_ctrl=0, occupancy=0, out_pc still A's pc. C never appears.
- Bubble: in_valid=0 for one cycle with ctrl=0xFF otherwise → that output cycle has out_valid=0 and out_ctrl=0x00.
- SKID=0: out_ready=0 with main full → in_ready=0 in the same cycle. Raise out_ready and in_valid together → in_ready=1, and the new beat replaces the drained one on the next edge.
- Reset while occupancy=2 → all outputs 0 and in_ready=1 on the next cycle. The first post-reset beat passes with 1-cycle latency.
